// File: rtl/sum_ascii_sequencer.sv
// Sum-to-ASCII frame sequencer: formats a captured 5-bit sum as two hex
// characters plus an optional CR/LF and feeds them one byte at a time to a
// UART transmitter over a start/busy handshake.
module sum_ascii_sequencer #(
   parameter int unsigned APPEND_CRLF = 1,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] sum_in,
   input  logic       send,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       seq_busy,
   output logic       ack_err
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [1:0] LAST_IDX = (APPEND_CRLF != 0) ? 2'd3 : 2'd1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StWaitHi, StWaitLo} state_e;

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [4:0]    sum_q, sum_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    data_q, data_d;
   logic          start_q, start_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          advance;

   // Character for position i of the frame built from sum s.
   function automatic logic [7:0] frame_byte(input logic [4:0] s, input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = s[4] ? 8'h31 : 8'h30;
         2'd1:    b = (s[3:0] < 4'd10) ? (8'h30 + {4'h0, s[3:0]}) : (8'h37 + {4'h0, s[3:0]});
         2'd2:    b = 8'h0D;
         default: b = 8'h0A;
      endcase
      return b;
   endfunction

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      timer_d = timer_q;
      data_d  = data_q;
      start_d = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      advance = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (send) begin
               sum_d   = sum_in;
               err_d   = 1'b0;
               idx_d   = 2'd0;
               data_d  = frame_byte(sum_in, 2'd0);
               busy_d  = 1'b1;
               state_d = StLoad;
            end
         end
         StLoad: begin
            if (!tx_busy) begin
               start_d = 1'b1;
               timer_d = '0;
               state_d = StWaitHi;
            end
         end
         StWaitHi: begin
            if (tx_busy) begin
               state_d = StWaitLo;
            end else if (timer_q == TIMER_LAST) begin
               // No acknowledge from the UART: flag it and move on anyway.
               err_d   = 1'b1;
               advance = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         StWaitLo: begin
            if (!tx_busy) begin
               advance = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end else begin
            idx_d   = idx_q + 2'd1;
            data_d  = frame_byte(sum_q, idx_q + 2'd1);
            state_d = StLoad;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         sum_q   <= 5'd0;
         timer_q <= '0;
         data_q  <= 8'h00;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         timer_q <= timer_d;
         data_q  <= data_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign tx_data  = data_q;
   assign tx_start = start_q;
   assign seq_busy = busy_q;
   assign ack_err  = err_q;

endmodule

// File: tb/tb_sum_ascii_sequencer.sv
// Self-checking bench: two sequencers (with and without CR/LF), each driving a
// simple UART busy model; captured bytes are compared against hex formatting.
module tb_sum_ascii_sequencer;

   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   logic [4:0] sum0, sum1;
   logic       send0, send1;
   logic       busy0, busy1;
   logic [7:0] tx_data0, tx_data1;
   logic       tx_start0, tx_start1, seq_busy0, seq_busy1, ack_err0, ack_err1;

   // UART model state
   logic mb0, mb1, force0, stuck0;
   int   cnt0, cnt1, len0, len1;
   logic [7:0] cap0[$];
   logic [7:0] cap1[$];
   logic [7:0] last0;
   int   unstable;

   int n_cmp = 0;
   int n_bad = 0;

   assign busy0 = mb0 | force0;
   assign busy1 = mb1;

   sum_ascii_sequencer #(.APPEND_CRLF(1), .ACK_TIMEOUT(TIMEOUT)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .sum_in(sum0), .send(send0), .tx_busy(busy0),
      .tx_data(tx_data0), .tx_start(tx_start0), .seq_busy(seq_busy0), .ack_err(ack_err0)
   );

   sum_ascii_sequencer #(.APPEND_CRLF(0), .ACK_TIMEOUT(TIMEOUT)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .sum_in(sum1), .send(send1), .tx_busy(busy1),
      .tx_data(tx_data1), .tx_start(tx_start1), .seq_busy(seq_busy1), .ack_err(ack_err1)
   );

   // UART busy models: a start strobe makes busy high for len cycles.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mb0 <= 1'b0; cnt0 <= 0; mb1 <= 1'b0; cnt1 <= 0;
      end else begin
         if (mb0) begin
            if (cnt0 <= 1) mb0 <= 1'b0;
            cnt0 <= cnt0 - 1;
         end else if (tx_start0 && !stuck0) begin
            mb0 <= 1'b1; cnt0 <= len0;
         end
         if (mb1) begin
            if (cnt1 <= 1) mb1 <= 1'b0;
            cnt1 <= cnt1 - 1;
         end else if (tx_start1) begin
            mb1 <= 1'b1; cnt1 <= len1;
         end
      end
   end

   // Byte capture at every start strobe.
   always @(posedge clk) begin
      if (reset_n && tx_start0) cap0.push_back(tx_data0);
      if (reset_n && tx_start1) cap1.push_back(tx_data1);
   end

   // tx_data must not move while the UART is transmitting.
   always @(negedge clk) begin
      if (mb0 && tx_data0 != last0) unstable = unstable + 1;
      last0 = tx_data0;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp = n_cmp + 1;
      if (got != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: ASCII hex of the sum, then CR LF.
   function automatic int exp_byte(input int s, input int i);
      int d;
      if (i == 2) return 13;
      if (i == 3) return 10;
      d = (i == 0) ? s / 16 : s % 16;
      return (d < 10) ? 48 + d : 65 + d - 10;
   endfunction

   function automatic int cap_byte(input int w, input int i);
      if (w == 0) return (i < cap0.size()) ? int'(cap0[i]) : -1;
      return (i < cap1.size()) ? int'(cap1[i]) : -1;
   endfunction

   function automatic int cap_size(input int w);
      return (w == 0) ? cap0.size() : cap1.size();
   endfunction

   function automatic bit sbusy(input int w);
      return (w == 0) ? seq_busy0 : seq_busy1;
   endfunction

   // Pulse send for one cycle, then scramble sum_in to prove it was captured.
   task automatic send_pulse(input int w, input int s);
      @(negedge clk);
      if (w == 0) begin sum0 = 5'(s); send0 = 1'b1; end
      else        begin sum1 = 5'(s); send1 = 1'b1; end
      @(negedge clk);
      if (w == 0) begin send0 = 1'b0; sum0 = 5'($urandom); end
      else        begin send1 = 1'b0; sum1 = 5'($urandom); end
   endtask

   // Count negedges with seq_busy high until it falls (bounded).
   task automatic wait_idle(input int w, input int limit, output int hi);
      hi = 0;
      while (sbusy(w) && hi < limit) begin
         hi = hi + 1;
         @(negedge clk);
      end
      if (sbusy(w)) check_eq("frame_end_timeout", 1, 0);
   endtask

   task automatic check_bytes(input int w, input int s, input int nb, input int offs);
      for (int i = 0; i < nb; i++)
         check_eq($sformatf("w%0d_s%0d_byte%0d", w, s, i), cap_byte(w, offs + i), exp_byte(s, i));
   endtask

   // One complete frame with a well-behaved UART of busy length len.
   task automatic do_frame(input int w, input int s, input int len);
      int hi;
      int nb;
      nb = (w == 0) ? 4 : 2;
      if (w == 0) begin len0 = len; cap0.delete(); end
      else        begin len1 = len; cap1.delete(); end
      unstable = 0;
      send_pulse(w, s);
      check_eq("busy_after_accept", int'(sbusy(w)), 1);
      check_eq("byte0_after_accept", (w == 0) ? int'(tx_data0) : int'(tx_data1), exp_byte(s, 0));
      check_eq("ack_err_cleared", (w == 0) ? int'(ack_err0) : int'(ack_err1), 0);
      wait_idle(w, 500, hi);
      check_eq("strobe_count", cap_size(w), nb);
      check_bytes(w, s, nb, 0);
      check_eq("frame_cycles", hi, nb * (len + 3));
      check_eq("tx_busy_low_at_end", (w == 0) ? int'(busy0) : int'(busy1), 0);
      check_eq("data_stable", unstable, 0);
   endtask

   initial begin
      int hi;
      int gap;
      int s;
      reset_n = 1'b0;
      sum0 = '0; sum1 = '0; send0 = 1'b0; send1 = 1'b0;
      force0 = 1'b0; stuck0 = 1'b0; len0 = 10; len1 = 10;
      unstable = 0; last0 = '0;
      #1;
      check_eq("rst_tx_data", int'(tx_data0), 0);
      check_eq("rst_tx_start", int'(tx_start0), 0);
      check_eq("rst_seq_busy", int'(seq_busy0), 0);
      check_eq("rst_ack_err", int'(ack_err0), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed frames.
      do_frame(0, 12, 10);
      do_frame(0, 31, 10);
      do_frame(1, 9, 10);

      // UART busy at accept: no strobe until it drops.
      cap0.delete();
      len0 = 4;
      @(negedge clk);
      force0 = 1'b1;
      send_pulse(0, 5);
      repeat (20) @(negedge clk);
      check_eq("held_no_strobe", cap0.size(), 0);
      check_eq("held_seq_busy", int'(seq_busy0), 1);
      force0 = 1'b0;
      wait_idle(0, 500, hi);
      check_eq("held_strobe_count", cap0.size(), 4);
      check_bytes(0, 5, 4, 0);

      // Re-pulse send with a new sum mid-frame: ignored.
      cap0.delete();
      len0 = 6;
      send_pulse(0, 18);
      repeat (12) @(negedge clk);
      sum0 = 5'd7; send0 = 1'b1;
      @(negedge clk);
      send0 = 1'b0;
      wait_idle(0, 500, hi);
      repeat (10) @(negedge clk);
      check_eq("repulse_strobes", cap0.size(), 4);
      check_bytes(0, 18, 4, 0);
      check_eq("repulse_idle", int'(seq_busy0), 0);

      // UART never acknowledges: every byte times out.
      cap0.delete();
      stuck0 = 1'b1;
      send_pulse(0, 26);
      wait_idle(0, 500, hi);
      check_eq("stuck_cycles", hi, 4 * (TIMEOUT + 1));
      check_eq("stuck_strobes", cap0.size(), 4);
      check_bytes(0, 26, 4, 0);
      check_eq("stuck_ack_err", int'(ack_err0), 1);
      stuck0 = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("ack_err_sticky", int'(ack_err0), 1);

      // Randomized frames on both instances.
      for (int k = 0; k < 8; k++)
         do_frame(0, int'($urandom_range(0, 31)), int'($urandom_range(1, 12)));
      for (int k = 0; k < 3; k++)
         do_frame(1, int'($urandom_range(0, 31)), int'($urandom_range(1, 12)));

      // send held high: back-to-back frames with a one-cycle gap.
      cap0.delete();
      len0 = 3;
      s = int'($urandom_range(0, 31));
      @(negedge clk);
      sum0 = 5'(s); send0 = 1'b1;
      @(negedge clk);
      wait_idle(0, 500, hi);
      gap = 0;
      while (!seq_busy0 && gap < 10) begin
         gap = gap + 1;
         @(negedge clk);
      end
      send0 = 1'b0;
      check_eq("held_send_gap", gap, 1);
      wait_idle(0, 500, hi);
      check_eq("held_send_strobes", cap0.size(), 8);
      check_bytes(0, s, 4, 0);
      check_bytes(0, s, 4, 4);

      // Asynchronous reset during byte 1.
      cap0.delete();
      len0 = 10;
      send_pulse(0, 20);
      gap = 0;
      while (cap0.size() < 2 && gap < 200) begin
         gap = gap + 1;
         @(negedge clk);
      end
      check_eq("reached_byte1", cap0.size(), 2);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_eq("midrst_tx_data", int'(tx_data0), 0);
      check_eq("midrst_tx_start", int'(tx_start0), 0);
      check_eq("midrst_seq_busy", int'(seq_busy0), 0);
      check_eq("midrst_ack_err", int'(ack_err0), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_frame(0, 20, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
